// File: rtl/arashi_mem_req_queue.sv
// Per-thread read-address FIFOs feeding the memory-read arbiter.
// Pops the granted thread's head entry and issues it as a registered read command.
module arashi_mem_req_queue #(
   parameter  int MEM_WIDTH        = 32,
   parameter  int THREAD_NUM_WIDTH = 2,
   parameter  int DEPTH_WIDTH      = 2,
   localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH,
   localparam int DEPTH            = 1 << DEPTH_WIDTH
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [THREAD_NUM-1:0]           i_push_valid,
   input  logic [THREAD_NUM*MEM_WIDTH-1:0] i_push_addr,
   output logic [THREAD_NUM-1:0]           o_push_ready,
   output logic [THREAD_NUM-1:0]           o_avail,
   input  logic [THREAD_NUM-1:0]           i_r_ena,
   output logic                            o_rd_valid,
   output logic [MEM_WIDTH-1:0]            o_rd_addr,
   output logic [THREAD_NUM_WIDTH-1:0]     o_rd_tid,
   output logic                            o_err_grant
);

   logic [MEM_WIDTH-1:0]        r_mem  [THREAD_NUM][DEPTH];
   logic [DEPTH_WIDTH-1:0]      r_wptr [THREAD_NUM];
   logic [DEPTH_WIDTH-1:0]      r_rptr [THREAD_NUM];
   logic [DEPTH_WIDTH:0]        r_cnt  [THREAD_NUM];

   logic [THREAD_NUM-1:0]       w_push;
   logic [THREAD_NUM-1:0]       w_elig;
   logic [THREAD_NUM-1:0]       w_pop;
   logic                        w_any_pop;
   logic                        w_multi;
   logic [THREAD_NUM_WIDTH-1:0] w_pop_tid;
   logic [MEM_WIDTH-1:0]        w_head;

   always_comb begin
      o_push_ready = '0;
      o_avail      = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
         o_push_ready[t] = (r_cnt[t] != (DEPTH_WIDTH+1)'(DEPTH));
         o_avail[t]      = (r_cnt[t] != '0);
      end
   end

   assign w_push    = i_push_valid & o_push_ready;
   assign w_elig    = i_r_ena & o_avail;
   // Isolate the lowest eligible thread so a bad grant still pops at most one entry.
   assign w_pop     = w_elig & (~w_elig + 1'b1);
   assign w_any_pop = |w_pop;
   assign w_multi   = |(i_r_ena & (i_r_ena - 1'b1));

   always_comb begin
      w_pop_tid = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
         if (w_pop[t]) w_pop_tid = THREAD_NUM_WIDTH'(t);
      end
   end

   assign w_head = r_mem[w_pop_tid][r_rptr[w_pop_tid]];

   always_ff @(posedge clk) begin
      for (int t = 0; t < THREAD_NUM; t++) begin
         if (w_push[t]) r_mem[t][r_wptr[t]] <= i_push_addr[t*MEM_WIDTH +: MEM_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int t = 0; t < THREAD_NUM; t++) begin
            r_wptr[t] <= '0;
            r_rptr[t] <= '0;
            r_cnt[t]  <= '0;
         end
      end else begin
         for (int t = 0; t < THREAD_NUM; t++) begin
            if (w_push[t]) r_wptr[t] <= r_wptr[t] + 1'b1;
            if (w_pop[t])  r_rptr[t] <= r_rptr[t] + 1'b1;
            case ({w_push[t], w_pop[t]})
               2'b10:   r_cnt[t] <= r_cnt[t] + 1'b1;
               2'b01:   r_cnt[t] <= r_cnt[t] - 1'b1;
               default: r_cnt[t] <= r_cnt[t];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_rd_valid  <= 1'b0;
         o_rd_addr   <= '0;
         o_rd_tid    <= '0;
         o_err_grant <= 1'b0;
      end else begin
         o_rd_valid <= w_any_pop;
         if (w_any_pop) begin
            o_rd_addr <= w_head;
            o_rd_tid  <= w_pop_tid;
         end
         if (w_multi) o_err_grant <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arashi_mem_req_queue.sv
// Directed bench for arashi_mem_req_queue: queue-based reference model checked every
// cycle, plus literal expectations on the emitted command streams.
module tb_arashi_mem_req_queue;

   logic         clk = 1'b0;
   logic         rstn;
   logic [3:0]   i_push_valid;
   logic [127:0] i_push_addr;
   logic [3:0]   o_push_ready;
   logic [3:0]   o_avail;
   logic [3:0]   i_r_ena;
   logic         o_rd_valid;
   logic [31:0]  o_rd_addr;
   logic [1:0]   o_rd_tid;
   logic         o_err_grant;

   arashi_mem_req_queue #(
      .MEM_WIDTH(32), .THREAD_NUM_WIDTH(2), .DEPTH_WIDTH(2)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_push_valid (i_push_valid),
      .i_push_addr  (i_push_addr),
      .o_push_ready (o_push_ready),
      .o_avail      (o_avail),
      .i_r_ena      (i_r_ena),
      .o_rd_valid   (o_rd_valid),
      .o_rd_addr    (o_rd_addr),
      .o_rd_tid     (o_rd_tid),
      .o_err_grant  (o_err_grant)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   logic [31:0] q [4][$];
   logic        m_on = 1'b0;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [1:0]  m_tid;
   logic        m_err;

   logic [31:0] log_addr [$];
   logic [1:0]  log_tid  [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one FIFO queue per thread, advanced once per clock edge.
   task automatic model_step();
      bit full [4];
      int sel;
      if (!rstn) begin
         for (int t = 0; t < 4; t++) q[t].delete();
         m_valid = 1'b0; m_addr = '0; m_tid = '0; m_err = 1'b0;
         m_on = 1'b1;
         return;
      end
      for (int t = 0; t < 4; t++) full[t] = (q[t].size() == 4);
      sel = -1;
      for (int t = 3; t >= 0; t--)
         if (i_r_ena[t] && q[t].size() != 0) sel = t;
      if ($countones(i_r_ena) > 1) m_err = 1'b1;
      if (sel >= 0) begin
         m_valid = 1'b1;
         m_addr  = q[sel].pop_front();
         m_tid   = 2'(sel);
      end else begin
         m_valid = 1'b0;
      end
      for (int t = 0; t < 4; t++)
         if (i_push_valid[t] && !full[t]) q[t].push_back(i_push_addr[t*32 +: 32]);
   endtask

   initial forever begin
      @(negedge clk);
      if (m_on) begin
         for (int t = 0; t < 4; t++) begin
            chk($sformatf("avail[%0d]", t), {31'b0, o_avail[t]}, {31'b0, q[t].size() != 0});
            chk($sformatf("push_ready[%0d]", t), {31'b0, o_push_ready[t]}, {31'b0, q[t].size() != 4});
         end
         chk("rd_valid", {31'b0, o_rd_valid}, {31'b0, m_valid});
         chk("rd_addr", o_rd_addr, m_addr);
         chk("rd_tid", {30'b0, o_rd_tid}, {30'b0, m_tid});
         chk("err_grant", {31'b0, o_err_grant}, {31'b0, m_err});
      end
   end

   function automatic logic [127:0] pa1(input int t, input logic [31:0] a);
      logic [127:0] v;
      v = {96'b0, a};
      return v << (t*32);
   endfunction

   task automatic cycle(input logic rs, input logic [3:0] pv, input logic [127:0] pa,
                        input logic [3:0] re);
      rstn = rs; i_push_valid = pv; i_push_addr = pa; i_r_ena = re;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      if (o_rd_valid) begin
         log_addr.push_back(o_rd_addr);
         log_tid.push_back(o_rd_tid);
      end
   endtask

   task automatic do_reset();
      cycle(1'b0, 4'h0, '0, 4'h0);
      log_addr.delete();
      log_tid.delete();
   endtask

   initial begin
      logic [31:0] exp_a [6];
      logic [1:0]  exp_t [6];

      // Reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 4'h0, '0, 4'h0);
         chk("idle avail", {28'b0, o_avail}, 32'h0);
         chk("idle push_ready", {28'b0, o_push_ready}, 32'hf);
         chk("idle rd_valid", {31'b0, o_rd_valid}, 32'h0);
      end

      // Reset mid-operation with 3 entries on thread 1
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0010, pa1(1, 32'h20 + 32'(i)), 4'h0);
      chk("pre-reset avail", {28'b0, o_avail}, 32'h2);
      cycle(1'b0, 4'h0, '0, 4'b0010);
      chk("midrst avail", {28'b0, o_avail}, 32'h0);
      chk("midrst push_ready", {28'b0, o_push_ready}, 32'hf);
      chk("midrst rd_valid", {31'b0, o_rd_valid}, 32'h0);
      cycle(1'b1, 4'h0, '0, 4'b0010);
      chk("post-rst rd_valid", {31'b0, o_rd_valid}, 32'h0);

      // Single thread with held grant
      do_reset();
      cycle(1'b1, 4'b0100, pa1(2, 32'h10), 4'b0100);
      cycle(1'b1, 4'b0100, pa1(2, 32'h14), 4'b0100);
      cycle(1'b1, 4'b0100, pa1(2, 32'h18), 4'b0100);
      cycle(1'b1, 4'b0000, '0, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 4'b0000, '0, 4'b0100);
         chk("single idle rd_valid", {31'b0, o_rd_valid}, 32'h0);
         chk("single idle err", {31'b0, o_err_grant}, 32'h0);
      end
      chk("single count", 32'(log_addr.size()), 32'd3);
      for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
         chk("single addr", log_addr[i], 32'h10 + 32'(4*i));
         chk("single tid", {30'b0, log_tid[i]}, 32'd2);
      end

      // Full FIFO: refused push concurrent with pop
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0001, pa1(0, 32'h40 + 32'(4*i)), 4'h0);
      chk("full push_ready0", {31'b0, o_push_ready[0]}, 32'h0);
      cycle(1'b1, 4'b0001, pa1(0, 32'h50), 4'b0001);
      chk("full pop valid", {31'b0, o_rd_valid}, 32'h1);
      chk("full pop addr", o_rd_addr, 32'h40);
      chk("full after push_ready0", {31'b0, o_push_ready[0]}, 32'h1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0000, '0, 4'b0001);
      chk("full drained", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_addr.size(); i++)
         chk("full addr", log_addr[i], 32'h40 + 32'(4*i));

      // Wrap-around stream on thread 3
      do_reset();
      for (int k = 0; k < 10; k++) cycle(1'b1, 4'b1000, pa1(3, 32'(k)), 4'b1000);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, '0, 4'b1000);
      chk("wrap count", 32'(log_addr.size()), 32'd10);
      for (int k = 0; k < 10 && k < log_addr.size(); k++) begin
         chk("wrap addr", log_addr[k], 32'(k));
         chk("wrap tid", {30'b0, log_tid[k]}, 32'd3);
      end

      // Round-robin grants over threads 0, 1, 3
      do_reset();
      cycle(1'b1, 4'b1011, pa1(0, 32'h100) | pa1(1, 32'h200) | pa1(3, 32'h300), 4'h0);
      cycle(1'b1, 4'b1011, pa1(0, 32'h104) | pa1(1, 32'h204) | pa1(3, 32'h304), 4'h0);
      cycle(1'b1, 4'h0, '0, 4'b0001);
      cycle(1'b1, 4'h0, '0, 4'b0010);
      cycle(1'b1, 4'h0, '0, 4'b1000);
      cycle(1'b1, 4'h0, '0, 4'b0001);
      cycle(1'b1, 4'h0, '0, 4'b0010);
      cycle(1'b1, 4'h0, '0, 4'b1000);
      cycle(1'b1, 4'h0, '0, 4'b0000);
      cycle(1'b1, 4'h0, '0, 4'b0000);
      exp_a = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h204, 32'h304};
      exp_t = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      chk("rr count", 32'(log_addr.size()), 32'd6);
      for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
         chk("rr addr", log_addr[i], exp_a[i]);
         chk("rr tid", {30'b0, log_tid[i]}, {30'b0, exp_t[i]});
      end

      // Non-one-hot grant
      do_reset();
      cycle(1'b1, 4'b0110, pa1(1, 32'hA0) | pa1(2, 32'hB0), 4'h0);
      chk("bad pre err", {31'b0, o_err_grant}, 32'h0);
      cycle(1'b1, 4'h0, '0, 4'b0110);
      chk("bad valid", {31'b0, o_rd_valid}, 32'h1);
      chk("bad tid", {30'b0, o_rd_tid}, 32'd1);
      chk("bad addr", o_rd_addr, 32'hA0);
      chk("bad err", {31'b0, o_err_grant}, 32'h1);
      chk("bad avail", {28'b0, o_avail}, 32'h4);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 4'h0, '0, 4'b0000);
         chk("bad err sticky", {31'b0, o_err_grant}, 32'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
